xm_mem_arbiter: RTL and testbench
=================================

// Module: xm_mem_arbiter
// PURPOSE
//  Shares the single-port memory between the CPU controller (fetch/load/store) and a DMA requester.
//  Round-robin arbitration, one access in flight. Drives byte lanes, checks alignment and watchdogs a
//  stalled memory. Returns per-port busy/done/err; cpu_busy_o feeds the controller's memBusy_i.
// PARAMETERS
//  WORD     16  data/address width
//  TIMEOUT  64  max ACCESS cycles without mem_ack_i before abort; 0 disables watchdog
// PORTS
//  clk_i        in   1     clock; all logic on posedge clk_i
//  srstn_i      in   1     synchronous active-low reset
//  cpu_req_i    in   1     CPU request, level, held until cpu_done_o/cpu_err_o
//  cpu_rw_i     in   1     1=write, 0=read
//  cpu_byte_i   in   1     1=byte access, 0=word
//  cpu_adr_i    in   WORD  byte address
//  cpu_wdata_i  in   WORD  write data (byte op: [7:0])
//  cpu_busy_o   out  1     cpu_req_i & ~cpu_done_o & ~cpu_err_o
//  cpu_done_o   out  1     1-cycle pulse: access complete
//  cpu_err_o    out  1     1-cycle pulse: misaligned or timeout
//  dma_req_i, dma_rw_i, dma_byte_i, dma_adr_i, dma_wdata_i     in   as CPU port
//  dma_busy_o, dma_done_o, dma_err_o                           out  as CPU port
//  rdata_o      out  WORD  read data, valid with *_done_o of a read; holds until next read completes
//  mem_en_o     out  1     memory enable, held high for the whole ACCESS state
//  mem_rw_o     out  1     1=write
//  mem_be_o     out  2     byte enables {hi,lo}
//  mem_adr_o    out  WORD  word address = latched adr with bit0 cleared
//  mem_wdata_o  out  WORD  write data; byte op replicated {wdata[7:0],wdata[7:0]}
//  mem_rdata_i  in   WORD  read data, valid with mem_ack_i
//  mem_ack_i    in   1     access complete; sampled only in ACCESS
// BEHAVIOUR
//  Reset (srstn_i=0 at posedge): state=IDLE, last_grant=DMA, timer=0; every output reg 0. Mid-access
//   reset drops mem_en_o on that edge, pulses no done/err, and discards the in-flight access.
//  FSM states:
//   IDLE: only state that arbitrates.
//    One req -> grant it. Both -> grant port != last_grant; the first tie after reset goes to CPU.
//    Grant: latch rw/byte/adr/wdata and the port; set last_grant.
//    Word op with adr[0]=1 -> ERR, no memory cycle. Otherwise -> ACCESS.
//   ACCESS: mem_en_o=1 with latched controls; timer++ each cycle.
//    mem_ack_i -> DONE; read data captured into rdata_o on this edge.
//    TIMEOUT!=0 and timer==TIMEOUT-1 with no ack -> ERR, mem_en_o drops.
//   DONE: granted port's done_o=1 for one cycle -> IDLE; timer cleared.
//   ERR: granted port's err_o=1 for one cycle; rdata_o unchanged -> IDLE; timer cleared.
//  Requester rule: drop or change req in the cycle done/err is seen. No grant in DONE/ERR, so the
//   requester's next request is granted in IDLE one cycle later.
//  Latency, zero-wait memory (ack in first ACCESS cycle):
//   req@c0 -> ACCESS c1 -> done@c2 -> IDLE c3; back-to-back access every 3 cycles.
//  Byte lanes: byte op, be = adr[0] ? 2'b10 : 2'b01; word op, be = 2'b11.
//  Byte read: rdata_o = {8'h00, selected byte}, zero-extended.
//  Latched request is immune to changes of *_req_i/*_adr_i after grant.
//  Ack in IDLE/DONE/ERR is ignored.
//  Timer width is clog2(TIMEOUT+1).
// STRUCTURE
//  xm_pkg: arb_state_t {IDLE,ACCESS,DONE,ERR}; port_t {PORT_CPU,PORT_DMA};
//   BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11.
//  Sub-module xm_byte_lane (combinational): byte/adr[0] -> mem_be, write replication, read lane
//   extract + zero-extend. Arbiter, FSM and timer live in xm_mem_arbiter.
// TESTING
//  1 CPU word read adr=0x0010, ack in 1st ACCESS cycle, mem_rdata=0xBEEF
//    -> mem_adr_o=0x0010, be=11, cpu_done_o@c2, rdata_o=0xBEEF
//  2 Both req held for 4 accesses
//    -> grants CPU,DMA,CPU,DMA; each port's done 3 cycles apart; no grant during DONE
//  3 DMA byte write adr=0x0021, wdata=0x12AB
//    -> mem_adr_o=0x0020, be=10, mem_wdata_o=0xABAB; byte read adr=0x0021, rdata_i=0x5A3C
//    -> rdata_o=0x005A
//  4 CPU word read adr=0x0013 -> cpu_err_o one cycle after grant, mem_en_o never high, rdata_o unchanged
//  5 TIMEOUT=4, no ack -> mem_en_o high exactly 4 cycles, err pulse, IDLE;
//    TIMEOUT=0 with ack after 100 cycles -> done, no err
//  6 srstn_i low during ACCESS -> next edge mem_en_o=0, no done/err; first tie after release grants CPU

Source files
------------

// File: rtl/xm_mem_arbiter_pkg.sv
// Shared types and byte-lane constants for the memory arbiter slice.
package xm_mem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} arb_state_t;
  typedef enum logic {PORT_CPU, PORT_DMA} port_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Byte ops hit one lane selected by the address LSB; word ops hit both.
  function automatic logic [1:0] lane_be(input logic byte_op, input logic adr0);
    if (!byte_op) return BE_WORD;
    return adr0 ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/xm_mem_arbiter_if.sv
// Requester ports (CPU, DMA), shared read data and the single-port memory bus.
interface xm_mem_arbiter_if #(parameter int WORD = 16);

  logic            cpu_req_i;
  logic            cpu_rw_i;
  logic            cpu_byte_i;
  logic [WORD-1:0] cpu_adr_i;
  logic [WORD-1:0] cpu_wdata_i;
  logic            cpu_busy_o;
  logic            cpu_done_o;
  logic            cpu_err_o;

  logic            dma_req_i;
  logic            dma_rw_i;
  logic            dma_byte_i;
  logic [WORD-1:0] dma_adr_i;
  logic [WORD-1:0] dma_wdata_i;
  logic            dma_busy_o;
  logic            dma_done_o;
  logic            dma_err_o;

  logic [WORD-1:0] rdata_o;

  logic            mem_en_o;
  logic            mem_rw_o;
  logic [1:0]      mem_be_o;
  logic [WORD-1:0] mem_adr_o;
  logic [WORD-1:0] mem_wdata_o;
  logic [WORD-1:0] mem_rdata_i;
  logic            mem_ack_i;

  // Arbiter side.
  modport master (
    input  cpu_req_i, cpu_rw_i, cpu_byte_i, cpu_adr_i, cpu_wdata_i,
    output cpu_busy_o, cpu_done_o, cpu_err_o,
    input  dma_req_i, dma_rw_i, dma_byte_i, dma_adr_i, dma_wdata_i,
    output dma_busy_o, dma_done_o, dma_err_o,
    output rdata_o,
    output mem_en_o, mem_rw_o, mem_be_o, mem_adr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  // Requesters plus memory side.
  modport slave (
    output cpu_req_i, cpu_rw_i, cpu_byte_i, cpu_adr_i, cpu_wdata_i,
    input  cpu_busy_o, cpu_done_o, cpu_err_o,
    output dma_req_i, dma_rw_i, dma_byte_i, dma_adr_i, dma_wdata_i,
    input  dma_busy_o, dma_done_o, dma_err_o,
    input  rdata_o,
    input  mem_en_o, mem_rw_o, mem_be_o, mem_adr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/xm_mem_arbiter_byte_lane.sv
// Byte-lane steering: enables, write replication, read lane extract with zero-extend.
// Latency: combinational.
// Backpressure: none, pure function of the latched request and memory read data.
module xm_byte_lane
  import xm_mem_arbiter_pkg::*;
#(
  parameter int WORD = 16
) (
  input  logic            byte_op,
  input  logic            adr0,
  input  logic [WORD-1:0] wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic [1:0]      be,
  output logic [WORD-1:0] mem_wdata,
  output logic [WORD-1:0] rdata
);

  logic [7:0] lane;

  assign be        = lane_be(byte_op, adr0);
  assign mem_wdata = byte_op ? WORD'({wdata[7:0], wdata[7:0]}) : wdata;
  assign lane      = adr0 ? mem_rdata[15:8] : mem_rdata[7:0];
  assign rdata     = byte_op ? WORD'(lane) : mem_rdata;

endmodule

// File: rtl/xm_mem_arbiter.sv
// Round-robin CPU/DMA arbiter for a single-port memory, one access in flight, with watchdog.
// Latency: req -> ACCESS next cycle -> done/err the cycle after ack; 3 cycles per zero-wait access.
// Backpressure: requests are levels held until done/err; busy tells the requester to keep waiting.
module xm_mem_arbiter
  import xm_mem_arbiter_pkg::*;
#(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           srstn_i,
  xm_mem_arbiter_if.master bus
);

  // A zero TIMEOUT still gets a 1-bit timer; it simply wraps and is never compared.
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic            rw;
    logic            byte_op;
    logic [WORD-1:0] adr;
    logic [WORD-1:0] wdata;
  } req_t;

  arb_state_t      state_q, state_d;
  port_t           grant_q, grant_d;
  port_t           last_q,  last_d;
  req_t            req_q,   req_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [WORD-1:0] rdata_q, rdata_d;

  logic            cpu_sel, dma_sel;
  logic [1:0]      lane_be_w;
  logic [WORD-1:0] lane_wdata, lane_rdata;

  xm_byte_lane #(.WORD(WORD)) u_byte_lane (
    .byte_op   (req_q.byte_op),
    .adr0      (req_q.adr[0]),
    .wdata     (req_q.wdata),
    .mem_rdata (bus.mem_rdata_i),
    .be        (lane_be_w),
    .mem_wdata (lane_wdata),
    .rdata     (lane_rdata)
  );

  // On a tie the port that did not win last time goes first.
  assign cpu_sel = bus.cpu_req_i & (~bus.dma_req_i | (last_q == PORT_DMA));
  assign dma_sel = bus.dma_req_i & ~cpu_sel;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    req_d   = req_q;
    timer_d = timer_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_sel || dma_sel) begin
          grant_d = cpu_sel ? PORT_CPU : PORT_DMA;
          last_d  = grant_d;
          if (cpu_sel) begin
            req_d = '{rw: bus.cpu_rw_i, byte_op: bus.cpu_byte_i,
                      adr: bus.cpu_adr_i, wdata: bus.cpu_wdata_i};
          end else begin
            req_d = '{rw: bus.dma_rw_i, byte_op: bus.dma_byte_i,
                      adr: bus.dma_adr_i, wdata: bus.dma_wdata_i};
          end
          // Misaligned word access is rejected without touching memory.
          state_d = (!req_d.byte_op && req_d.adr[0]) ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        timer_d = timer_q + TW'(1);
        if (bus.mem_ack_i) begin
          state_d = DONE;
          if (!req_q.rw) rdata_d = lane_rdata;
        end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ERR;
        end
      end
      DONE, ERR: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srstn_i) begin
      state_q <= IDLE;
      grant_q <= PORT_CPU;
      last_q  <= PORT_DMA;
      req_q   <= '0;
      timer_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      req_q   <= req_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.mem_en_o    = (state_q == ACCESS);
  assign bus.mem_rw_o    = bus.mem_en_o & req_q.rw;
  assign bus.mem_be_o    = bus.mem_en_o ? lane_be_w : 2'b00;
  assign bus.mem_adr_o   = {req_q.adr[WORD-1:1], 1'b0};
  assign bus.mem_wdata_o = lane_wdata;
  assign bus.rdata_o     = rdata_q;

  assign bus.cpu_done_o  = (state_q == DONE) && (grant_q == PORT_CPU);
  assign bus.cpu_err_o   = (state_q == ERR)  && (grant_q == PORT_CPU);
  assign bus.dma_done_o  = (state_q == DONE) && (grant_q == PORT_DMA);
  assign bus.dma_err_o   = (state_q == ERR)  && (grant_q == PORT_DMA);

  assign bus.cpu_busy_o  = bus.cpu_req_i & ~bus.cpu_done_o & ~bus.cpu_err_o;
  assign bus.dma_busy_o  = bus.dma_req_i & ~bus.dma_done_o & ~bus.dma_err_o;

endmodule

// File: tb/tb_xm_mem_arbiter.sv
// Directed bench for xm_mem_arbiter: main instance with TIMEOUT=4, second with watchdog disabled.
module tb_xm_mem_arbiter;

  logic clk;
  logic srstn;
  logic auto_ack;
  int   checks;
  int   passes;

  xm_mem_arbiter_if #(.WORD(16)) bus  ();
  xm_mem_arbiter_if #(.WORD(16)) bus0 ();

  xm_mem_arbiter #(.WORD(16), .TIMEOUT(4)) u_dut (
    .clk_i   (clk),
    .srstn_i (srstn),
    .bus     (bus)
  );

  xm_mem_arbiter #(.WORD(16), .TIMEOUT(0)) u_dut0 (
    .clk_i   (clk),
    .srstn_i (srstn),
    .bus     (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge; optionally answer the main memory with zero wait.
  task automatic cyc();
    @(negedge clk);
    if (auto_ack) bus.mem_ack_i = bus.mem_en_o;
  endtask

  task automatic set_cpu(input logic req, input logic rw, input logic bt,
                         input logic [15:0] adr, input logic [15:0] wd);
    bus.cpu_req_i = req; bus.cpu_rw_i = rw; bus.cpu_byte_i = bt;
    bus.cpu_adr_i = adr; bus.cpu_wdata_i = wd;
  endtask

  task automatic set_dma(input logic req, input logic rw, input logic bt,
                         input logic [15:0] adr, input logic [15:0] wd);
    bus.dma_req_i = req; bus.dma_rw_i = rw; bus.dma_byte_i = bt;
    bus.dma_adr_i = adr; bus.dma_wdata_i = wd;
  endtask

  task automatic test_reset();
    srstn = 1'b0;
    cyc(); cyc();
    checks++; if (bus.mem_en_o !== 1'b0) $display("FAIL reset_en got %b want 0", bus.mem_en_o); else passes++;
    checks++; if (bus.rdata_o !== 16'h0000) $display("FAIL reset_rdata got %h want 0000", bus.rdata_o); else passes++;
    checks++; if (bus.mem_be_o !== 2'b00) $display("FAIL reset_be got %b want 00", bus.mem_be_o); else passes++;
    checks++; if (bus.mem_adr_o !== 16'h0000) $display("FAIL reset_adr got %h want 0000", bus.mem_adr_o); else passes++;
    checks++; if ({bus.cpu_done_o, bus.cpu_err_o, bus.dma_done_o, bus.dma_err_o} !== 4'b0000)
      $display("FAIL reset_pulses got %b want 0000", {bus.cpu_done_o, bus.cpu_err_o, bus.dma_done_o, bus.dma_err_o});
    else passes++;
    srstn = 1'b1;
    // Ack while idle must not start or finish anything.
    bus.mem_ack_i = 1'b1;
    cyc();
    checks++; if ({bus.mem_en_o, bus.cpu_done_o, bus.dma_done_o} !== 3'b000)
      $display("FAIL idle_ack got %b want 000", {bus.mem_en_o, bus.cpu_done_o, bus.dma_done_o});
    else passes++;
    bus.mem_ack_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic       exp_cd, exp_dd, exp_en;
    logic [15:0] exp_adr;
    auto_ack = 1'b1;
    bus.mem_rdata_i = 16'h1111;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
    set_dma(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_cd = (k == 2) || (k == 8);
      exp_dd = (k == 5) || (k == 11);
      exp_en = (k % 3) == 1;
      checks++; if (bus.cpu_done_o !== exp_cd) $display("FAIL rr_cpu_done k=%0d got %b want %b", k, bus.cpu_done_o, exp_cd); else passes++;
      checks++; if (bus.dma_done_o !== exp_dd) $display("FAIL rr_dma_done k=%0d got %b want %b", k, bus.dma_done_o, exp_dd); else passes++;
      checks++; if (bus.mem_en_o !== exp_en) $display("FAIL rr_en k=%0d got %b want %b", k, bus.mem_en_o, exp_en); else passes++;
      if (exp_en) begin
        exp_adr = (((k / 3) % 2) == 0) ? 16'h0100 : 16'h0200;
        checks++; if (bus.mem_adr_o !== exp_adr) $display("FAIL rr_adr k=%0d got %h want %h", k, bus.mem_adr_o, exp_adr); else passes++;
      end
      if (k == 11) begin
        bus.cpu_req_i = 1'b0;
        bus.dma_req_i = 1'b0;
      end
    end
  endtask

  task automatic test_word_read();
    auto_ack = 1'b1;
    bus.mem_rdata_i = 16'hBEEF;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
    cyc();
    checks++; if (bus.mem_en_o !== 1'b1) $display("FAIL wr_en got %b want 1", bus.mem_en_o); else passes++;
    checks++; if (bus.mem_adr_o !== 16'h0010) $display("FAIL wr_adr got %h want 0010", bus.mem_adr_o); else passes++;
    checks++; if (bus.mem_be_o !== 2'b11) $display("FAIL wr_be got %b want 11", bus.mem_be_o); else passes++;
    checks++; if (bus.mem_rw_o !== 1'b0) $display("FAIL wr_rw got %b want 0", bus.mem_rw_o); else passes++;
    checks++; if (bus.cpu_busy_o !== 1'b1) $display("FAIL wr_busy1 got %b want 1", bus.cpu_busy_o); else passes++;
    cyc();
    checks++; if (bus.cpu_done_o !== 1'b1) $display("FAIL wr_done got %b want 1", bus.cpu_done_o); else passes++;
    checks++; if (bus.rdata_o !== 16'hBEEF) $display("FAIL wr_rdata got %h want beef", bus.rdata_o); else passes++;
    checks++; if (bus.cpu_busy_o !== 1'b0) $display("FAIL wr_busy2 got %b want 0", bus.cpu_busy_o); else passes++;
    checks++; if (bus.mem_en_o !== 1'b0) $display("FAIL wr_en_done got %b want 0", bus.mem_en_o); else passes++;
    bus.cpu_req_i = 1'b0;
    cyc();
    checks++; if (bus.cpu_done_o !== 1'b0) $display("FAIL wr_done_pulse got %b want 0", bus.cpu_done_o); else passes++;
  endtask

  task automatic test_byte_lanes();
    auto_ack = 1'b1;
    set_dma(1'b1, 1'b1, 1'b1, 16'h0021, 16'h12AB);
    cyc();
    checks++; if (bus.mem_adr_o !== 16'h0020) $display("FAIL bw_adr got %h want 0020", bus.mem_adr_o); else passes++;
    checks++; if (bus.mem_be_o !== 2'b10) $display("FAIL bw_be got %b want 10", bus.mem_be_o); else passes++;
    checks++; if (bus.mem_wdata_o !== 16'hABAB) $display("FAIL bw_wdata got %h want abab", bus.mem_wdata_o); else passes++;
    checks++; if (bus.mem_rw_o !== 1'b1) $display("FAIL bw_rw got %b want 1", bus.mem_rw_o); else passes++;
    // Change the request after grant: the latched access must not move.
    bus.dma_adr_i = 16'h0300;
    cyc();
    checks++; if (bus.dma_done_o !== 1'b1) $display("FAIL bw_done got %b want 1", bus.dma_done_o); else passes++;
    checks++; if (bus.rdata_o !== 16'hBEEF) $display("FAIL bw_rdata_hold got %h want beef", bus.rdata_o); else passes++;
    bus.dma_req_i = 1'b0;
    cyc();
    bus.mem_rdata_i = 16'h5A3C;
    set_dma(1'b1, 1'b0, 1'b1, 16'h0021, 16'h0000);
    cyc();
    checks++; if (bus.mem_be_o !== 2'b10) $display("FAIL br_hi_be got %b want 10", bus.mem_be_o); else passes++;
    cyc();
    checks++; if (bus.rdata_o !== 16'h005A) $display("FAIL br_hi_rdata got %h want 005a", bus.rdata_o); else passes++;
    bus.dma_req_i = 1'b0;
    cyc();
    set_dma(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    cyc();
    checks++; if (bus.mem_be_o !== 2'b01) $display("FAIL br_lo_be got %b want 01", bus.mem_be_o); else passes++;
    cyc();
    checks++; if (bus.rdata_o !== 16'h003C) $display("FAIL br_lo_rdata got %h want 003c", bus.rdata_o); else passes++;
    bus.dma_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_misaligned();
    auto_ack = 1'b1;
    bus.mem_rdata_i = 16'hDEAD;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0013, 16'h0000);
    cyc();
    checks++; if (bus.cpu_err_o !== 1'b1) $display("FAIL mis_err got %b want 1", bus.cpu_err_o); else passes++;
    checks++; if (bus.mem_en_o !== 1'b0) $display("FAIL mis_en got %b want 0", bus.mem_en_o); else passes++;
    checks++; if (bus.cpu_done_o !== 1'b0) $display("FAIL mis_done got %b want 0", bus.cpu_done_o); else passes++;
    bus.cpu_req_i = 1'b0;
    cyc();
    checks++; if ({bus.cpu_err_o, bus.mem_en_o} !== 2'b00) $display("FAIL mis_after got %b want 00", {bus.cpu_err_o, bus.mem_en_o}); else passes++;
    checks++; if (bus.rdata_o !== 16'h003C) $display("FAIL mis_rdata got %h want 003c", bus.rdata_o); else passes++;
  endtask

  task automatic test_timeout();
    logic exp_en, exp_err;
    int   bad;
    auto_ack = 1'b0;
    bus.mem_ack_i = 1'b0;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      exp_en  = (k <= 4);
      exp_err = (k == 5);
      checks++; if (bus.mem_en_o !== exp_en) $display("FAIL to_en k=%0d got %b want %b", k, bus.mem_en_o, exp_en); else passes++;
      checks++; if (bus.cpu_err_o !== exp_err) $display("FAIL to_err k=%0d got %b want %b", k, bus.cpu_err_o, exp_err); else passes++;
      if (k == 5) bus.cpu_req_i = 1'b0;
    end
    // Watchdog disabled: a 100-cycle stall still completes normally.
    bus0.mem_rdata_i = 16'h1234;
    bus0.cpu_req_i = 1'b1; bus0.cpu_rw_i = 1'b0; bus0.cpu_byte_i = 1'b0;
    bus0.cpu_adr_i = 16'h0050; bus0.cpu_wdata_i = 16'h0000;
    bad = 0;
    for (int k = 1; k <= 99; k++) begin
      cyc();
      if (bus0.mem_en_o !== 1'b1 || bus0.cpu_err_o !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL nowd_stall bad_cycles got %0d want 0", bad); else passes++;
    cyc();
    bus0.mem_ack_i = 1'b1;
    cyc();
    bus0.mem_ack_i = 1'b0;
    checks++; if (bus0.cpu_done_o !== 1'b1) $display("FAIL nowd_done got %b want 1", bus0.cpu_done_o); else passes++;
    checks++; if (bus0.cpu_err_o !== 1'b0) $display("FAIL nowd_err got %b want 0", bus0.cpu_err_o); else passes++;
    checks++; if (bus0.rdata_o !== 16'h1234) $display("FAIL nowd_rdata got %h want 1234", bus0.rdata_o); else passes++;
    bus0.cpu_req_i = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_access();
    auto_ack = 1'b0;
    bus.mem_ack_i = 1'b0;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0060, 16'h0000);
    cyc();
    checks++; if (bus.mem_en_o !== 1'b1) $display("FAIL rst_mid_en got %b want 1", bus.mem_en_o); else passes++;
    srstn = 1'b0;
    cyc();
    checks++; if (bus.mem_en_o !== 1'b0) $display("FAIL rst_mid_drop got %b want 0", bus.mem_en_o); else passes++;
    checks++; if ({bus.cpu_done_o, bus.cpu_err_o} !== 2'b00) $display("FAIL rst_mid_pulse got %b want 00", {bus.cpu_done_o, bus.cpu_err_o}); else passes++;
    checks++; if (bus.rdata_o !== 16'h0000) $display("FAIL rst_mid_rdata got %h want 0000", bus.rdata_o); else passes++;
    srstn = 1'b1;
    auto_ack = 1'b1;
    set_cpu(1'b1, 1'b0, 1'b0, 16'h0070, 16'h0000);
    set_dma(1'b1, 1'b0, 1'b0, 16'h0080, 16'h0000);
    bus.mem_rdata_i = 16'h4321;
    cyc();
    checks++; if (bus.mem_adr_o !== 16'h0070) $display("FAIL rst_tie_adr got %h want 0070", bus.mem_adr_o); else passes++;
    cyc();
    checks++; if (bus.cpu_done_o !== 1'b1) $display("FAIL rst_tie_done got %b want 1", bus.cpu_done_o); else passes++;
    bus.cpu_req_i = 1'b0;
    bus.dma_req_i = 1'b0;
    cyc();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    auto_ack = 1'b0;
    srstn = 1'b0;
    set_cpu(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_dma(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    bus.mem_rdata_i = 16'h0000;
    bus.mem_ack_i = 1'b0;
    bus0.cpu_req_i = 1'b0; bus0.cpu_rw_i = 1'b0; bus0.cpu_byte_i = 1'b0;
    bus0.cpu_adr_i = 16'h0000; bus0.cpu_wdata_i = 16'h0000;
    bus0.dma_req_i = 1'b0; bus0.dma_rw_i = 1'b0; bus0.dma_byte_i = 1'b0;
    bus0.dma_adr_i = 16'h0000; bus0.dma_wdata_i = 16'h0000;
    bus0.mem_rdata_i = 16'h0000;
    bus0.mem_ack_i = 1'b0;

    test_reset();
    test_round_robin();
    test_word_read();
    test_byte_lanes();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
